// File: rtl/apb_imem_responder.sv
// APB3 completer for the instruction store: program load/readback on port A,
// registered core fetch on port B, plus load-window bookkeeping.
//
// state  | meaning
// IDLE   | waiting for psel & !penable
// SETUP  | request captured, wait counter loads next
// ACCESS | counting wait states; completes when counter hits zero
module apb_imem_responder #(
   parameter int DATA_LENGTH    = 32,
   parameter int ADDRESS_LENGTH = 11,
   parameter int DEPTH          = 2048,
   parameter int WAIT_STATES    = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [ADDRESS_LENGTH-1:0] paddr,
   input  logic                      psel,
   input  logic                      penable,
   input  logic                      pwrite,
   input  logic [DATA_LENGTH-1:0]    pwdata,
   output logic                      pready,
   output logic [DATA_LENGTH-1:0]    prdata,
   output logic                      pslverr,
   input  logic                      instruction_load_start,
   input  logic [ADDRESS_LENGTH-1:0] core_rd_addr,
   output logic [DATA_LENGTH-1:0]    core_rd_data,
   output logic [ADDRESS_LENGTH:0]   load_count,
   output logic                      load_done
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [ADDRESS_LENGTH:0] DEPTH_W   = DEPTH[ADDRESS_LENGTH:0];
   localparam logic [3:0]              WAIT_INIT = WAIT_STATES[3:0];

   logic [1:0]                state;
   logic [3:0]                wait_cnt;
   logic [ADDRESS_LENGTH-1:0] addr_q;
   logic                      wr_q;
   logic [DATA_LENGTH-1:0]    wdata_q;
   logic                      load_q;

   logic [DATA_LENGTH-1:0] mem [DEPTH];

   logic complete;
   logic addr_err;
   logic xfer_err;
   logic commit;
   logic core_in_range;

   // A transfer only completes while the initiator still holds psel.
   assign complete      = (state == ST_ACCESS) && psel && (wait_cnt == 4'd0);
   assign addr_err      = ({1'b0, addr_q} >= DEPTH_W);
   assign xfer_err      = addr_err | (wr_q & ~instruction_load_start);
   assign commit        = complete & wr_q & ~xfer_err;
   assign core_in_range = ({1'b0, core_rd_addr} < DEPTH_W);

   assign pready  = complete;
   assign pslverr = complete & xfer_err;
   assign prdata  = (complete && !wr_q && !xfer_err) ? mem[addr_q[IDX_W-1:0]] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         wait_cnt <= 4'd0;
         addr_q   <= '0;
         wr_q     <= 1'b0;
         wdata_q  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (psel && !penable) begin
                  state   <= ST_SETUP;
                  addr_q  <= paddr;
                  wr_q    <= pwrite;
                  wdata_q <= pwdata;
               end
            end
            ST_SETUP: begin
               state    <= ST_ACCESS;
               wait_cnt <= WAIT_INIT;
            end
            ST_ACCESS: begin
               if (!psel) begin
                  state <= ST_IDLE;
               end else if (wait_cnt != 4'd0) begin
                  wait_cnt <= wait_cnt - 4'd1;
               end else if (!penable) begin
                  state   <= ST_SETUP;
                  addr_q  <= paddr;
                  wr_q    <= pwrite;
                  wdata_q <= pwdata;
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (commit) mem[addr_q[IDX_W-1:0]] <= wdata_q;
   end

   // Nonblocking update gives the core the old word on a same-address write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) core_rd_data <= '0;
      else        core_rd_data <= core_in_range ? mem[core_rd_addr[IDX_W-1:0]] : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_q     <= 1'b0;
         load_done  <= 1'b0;
         load_count <= '0;
      end else begin
         load_q    <= instruction_load_start;
         load_done <= load_q & ~instruction_load_start;
         if (instruction_load_start && !load_q) begin
            load_count <= commit ? {{ADDRESS_LENGTH{1'b0}}, 1'b1} : '0;
         end else if (commit && load_count != DEPTH_W) begin
            load_count <= load_count + 1'b1;
         end
      end
   end

endmodule
